// File: rtl/score_pkg.sv
// Shared BCD types and helpers for the score tracker.
package score_pkg;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE   = 4'd9;
  localparam int         MAX_DIGITS = 6;

  // Returns {carry_out, digit}.
  function automatic logic [4:0] bcd_inc(input bcd_digit_t d, input logic cin);
    if (!cin) return {1'b0, d};
    if (d == BCD_NINE) return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  // Operands are zero-extended to MAX_DIGITS; compared digit-wise, MSD first.
  function automatic logic bcd_gt(input logic [MAX_DIGITS*4-1:0] a,
                                  input logic [MAX_DIGITS*4-1:0] b);
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (a[i*4 +: 4] != b[i*4 +: 4]) return a[i*4 +: 4] > b[i*4 +: 4];
    end
    return 1'b0;
  endfunction
endpackage

// File: rtl/bcd_channel_counter.sv
// One player's BCD score: rising-edge detect, clear/freeze priority, ripple increment.
module bcd_channel_counter
  import score_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                inc,
  input  logic                clear,
  input  logic                freeze,
  output logic [DIGITS*4-1:0] score,
  output logic                overflow
);
  localparam int W = DIGITS * 4;

  logic         inc_prev_q, inc_prev_d;
  logic [W-1:0] score_q, score_d;
  logic         overflow_q, overflow_d;
  logic [W-1:0] score_inc;
  logic         all_nines;
  logic         inc_edge;

  always_comb begin
    logic c;
    c         = 1'b1;
    score_inc = '0;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      {c, score_inc[i*4 +: 4]} = bcd_inc(score_q[i*4 +: 4], c);
      all_nines = all_nines & (score_q[i*4 +: 4] == BCD_NINE);
    end
  end

  always_comb begin
    inc_edge   = inc & ~inc_prev_q;
    inc_prev_d = inc;
    score_d    = score_q;
    overflow_d = 1'b0;
    // An edge blocked by clear or freeze is dropped, never deferred.
    if (clear) begin
      score_d = '0;
    end else if (!freeze && inc_edge) begin
      if (!all_nines) begin
        score_d = score_inc;
      end else if (!SATURATE) begin
        score_d    = '0;
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      inc_prev_q <= 1'b0;
      score_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      inc_prev_q <= inc_prev_d;
      score_q    <= score_d;
      overflow_q <= overflow_d;
    end
  end

  assign score    = score_q;
  assign overflow = overflow_q;
endmodule

// File: rtl/score_tracker.sv
// Multi-channel BCD score counter with session high score, feeding the HEX display path.
module score_tracker
  import score_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b1
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NUM_CH-1:0]          Inc,
  input  logic [NUM_CH-1:0]          Clear,
  input  logic                       Freeze,
  output logic [NUM_CH*DIGITS*4-1:0] Score,
  output logic [NUM_CH-1:0]          Overflow,
  output logic [DIGITS*4-1:0]        HighScore,
  output logic [$clog2(NUM_CH):0]    HighCh,
  output logic                       NewHigh
);
  localparam int W    = DIGITS * 4;
  localparam int CH_W = $clog2(NUM_CH) + 1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    bcd_channel_counter #(
      .DIGITS  (DIGITS),
      .SATURATE(SATURATE)
    ) u_ch (
      .Clock   (Clock),
      .Reset   (Reset),
      .inc     (Inc[g]),
      .clear   (Clear[g]),
      .freeze  (Freeze),
      .score   (Score[g*W +: W]),
      .overflow(Overflow[g])
    );
  end

  function automatic logic [MAX_DIGITS*4-1:0] widen(input logic [W-1:0] v);
    logic [MAX_DIGITS*4-1:0] r;
    r        = '0;
    r[W-1:0] = v;
    return r;
  endfunction

  logic [W-1:0]    high_score_q, high_score_d;
  logic [CH_W-1:0] high_ch_q, high_ch_d;
  logic            new_high_q, new_high_d;
  logic [W-1:0]    best_score;
  logic [CH_W-1:0] best_ch;

  always_comb begin
    best_score   = Score[W-1:0];
    best_ch      = '0;
    high_score_d = high_score_q;
    high_ch_d    = high_ch_q;
    new_high_d   = 1'b0;
    // Strict compare so a tie keeps the lowest channel index.
    for (int k = 1; k < NUM_CH; k++) begin
      if (bcd_gt(widen(Score[k*W +: W]), widen(best_score))) begin
        best_score = Score[k*W +: W];
        best_ch    = CH_W'(k);
      end
    end
    if (bcd_gt(widen(best_score), widen(high_score_q))) begin
      high_score_d = best_score;
      high_ch_d    = best_ch;
      new_high_d   = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      high_score_q <= '0;
      high_ch_q    <= '0;
      new_high_q   <= 1'b0;
    end else begin
      high_score_q <= high_score_d;
      high_ch_q    <= high_ch_d;
      new_high_q   <= new_high_d;
    end
  end

  assign HighScore = high_score_q;
  assign HighCh    = high_ch_q;
  assign NewHigh   = new_high_q;
endmodule
